// File: rtl/id_ex_pipeline_if.sv
// ID/EX pipeline bundle: decode-side fields, write-back port, redirect,
// and the registered EX-side view with load-use stall status.
interface id_ex_pipeline_if #(
    parameter int ALUOP_WIDTH = 4
);
    logic [31:0]            Read_Data_1_ID;
    logic [31:0]            Read_Data_2_ID;
    logic [31:0]            Immediate_ID;
    logic [4:0]             Rs_ID;
    logic [4:0]             Rt_ID;
    logic [4:0]             Rd_ID;
    logic                   Valid_ID;
    logic                   RegWrite_ID;
    logic                   MemRead_ID;
    logic                   MemWrite_ID;
    logic                   MemtoReg_ID;
    logic                   ALUSrc_ID;
    logic                   RegDst_ID;
    logic [ALUOP_WIDTH-1:0] ALUOp_ID;

    logic                   Flush_EX;

    logic                   RegWrite_WB;
    logic [4:0]             Write_Register_WB;
    logic [31:0]            Write_Data_WB;

    logic [31:0]            Read_Data_1_EX;
    logic [31:0]            Read_Data_2_EX;
    logic [31:0]            Immediate_EX;
    logic [4:0]             Rs_EX;
    logic [4:0]             Rt_EX;
    logic [4:0]             Rd_EX;
    logic                   Valid_EX;
    logic                   RegWrite_EX;
    logic                   MemRead_EX;
    logic                   MemWrite_EX;
    logic                   MemtoReg_EX;
    logic                   ALUSrc_EX;
    logic                   RegDst_EX;
    logic [ALUOP_WIDTH-1:0] ALUOp_EX;

    logic                   Stall_ID;
    logic [15:0]            Stall_Count;

    modport master (
        output Read_Data_1_ID, Read_Data_2_ID, Immediate_ID,
        output Rs_ID, Rt_ID, Rd_ID, Valid_ID,
        output RegWrite_ID, MemRead_ID, MemWrite_ID,
        output MemtoReg_ID, ALUSrc_ID, RegDst_ID, ALUOp_ID,
        output Flush_EX,
        output RegWrite_WB, Write_Register_WB, Write_Data_WB,
        input  Read_Data_1_EX, Read_Data_2_EX, Immediate_EX,
        input  Rs_EX, Rt_EX, Rd_EX, Valid_EX,
        input  RegWrite_EX, MemRead_EX, MemWrite_EX,
        input  MemtoReg_EX, ALUSrc_EX, RegDst_EX, ALUOp_EX,
        input  Stall_ID, Stall_Count
    );

    modport slave (
        input  Read_Data_1_ID, Read_Data_2_ID, Immediate_ID,
        input  Rs_ID, Rt_ID, Rd_ID, Valid_ID,
        input  RegWrite_ID, MemRead_ID, MemWrite_ID,
        input  MemtoReg_ID, ALUSrc_ID, RegDst_ID, ALUOp_ID,
        input  Flush_EX,
        input  RegWrite_WB, Write_Register_WB, Write_Data_WB,
        output Read_Data_1_EX, Read_Data_2_EX, Immediate_EX,
        output Rs_EX, Rt_EX, Rd_EX, Valid_EX,
        output RegWrite_EX, MemRead_EX, MemWrite_EX,
        output MemtoReg_EX, ALUSrc_EX, RegDst_EX, ALUOp_EX,
        output Stall_ID, Stall_Count
    );
endinterface

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with load-use stall detection, redirect flush,
// write-back write-through and a saturating stall-cycle counter.
module id_ex_pipeline #(
    parameter int          ALUOP_WIDTH = 4,
    parameter logic [15:0] STALL_SAT   = 16'hFFFF
) (
    input logic             Clk,
    input logic             Reset_n,
    id_ex_pipeline_if.slave bus
);

    typedef struct packed {
        logic [31:0]            rd1;
        logic [31:0]            rd2;
        logic [31:0]            imm;
        logic [4:0]             rs;
        logic [4:0]             rt;
        logic [4:0]             rd;
        logic                   valid;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic                   mem_to_reg;
        logic                   alu_src;
        logic                   reg_dst;
        logic [ALUOP_WIDTH-1:0] alu_op;
    } id_ex_t;

    id_ex_t      ex_q;
    id_ex_t      ex_d;
    id_ex_t      cap;
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    logic hazard;
    logic stall;
    logic kill;
    logic wb_hit_rs;
    logic wb_hit_rt;
    logic rt_hit;

    // Rt of the EX load is matched against both ID sources, whether or
    // not the ID instruction actually reads Rt.
    assign rt_hit = (ex_q.rt == bus.Rs_ID) | (ex_q.rt == bus.Rt_ID);

    assign hazard = ex_q.valid & ex_q.mem_read & bus.Valid_ID
                  & (ex_q.rt != 5'd0) & rt_hit;

    assign stall = hazard & ~bus.Flush_EX;
    assign kill  = bus.Flush_EX | stall | ~bus.Valid_ID;

    assign wb_hit_rs = bus.RegWrite_WB
                     & (bus.Write_Register_WB != 5'd0)
                     & (bus.Write_Register_WB == bus.Rs_ID);

    assign wb_hit_rt = bus.RegWrite_WB
                     & (bus.Write_Register_WB != 5'd0)
                     & (bus.Write_Register_WB == bus.Rt_ID);

    always_comb begin
        cap            = '0;
        cap.rd1        = wb_hit_rs ? bus.Write_Data_WB
                                   : bus.Read_Data_1_ID;
        cap.rd2        = wb_hit_rt ? bus.Write_Data_WB
                                   : bus.Read_Data_2_ID;
        cap.imm        = bus.Immediate_ID;
        cap.rs         = bus.Rs_ID;
        cap.rt         = bus.Rt_ID;
        cap.rd         = bus.Rd_ID;
        cap.valid      = bus.Valid_ID;
        cap.reg_write  = bus.RegWrite_ID;
        cap.mem_read   = bus.MemRead_ID;
        cap.mem_write  = bus.MemWrite_ID;
        cap.mem_to_reg = bus.MemtoReg_ID;
        cap.alu_src    = bus.ALUSrc_ID;
        cap.reg_dst    = bus.RegDst_ID;
        cap.alu_op     = bus.ALUOp_ID;
    end

    always_comb begin
        ex_d = cap;
        if (kill) begin
            ex_d = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != STALL_SAT)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Read_Data_1_EX = ex_q.rd1;
    assign bus.Read_Data_2_EX = ex_q.rd2;
    assign bus.Immediate_EX   = ex_q.imm;
    assign bus.Rs_EX          = ex_q.rs;
    assign bus.Rt_EX          = ex_q.rt;
    assign bus.Rd_EX          = ex_q.rd;
    assign bus.Valid_EX       = ex_q.valid;
    assign bus.RegWrite_EX    = ex_q.reg_write;
    assign bus.MemRead_EX     = ex_q.mem_read;
    assign bus.MemWrite_EX    = ex_q.mem_write;
    assign bus.MemtoReg_EX    = ex_q.mem_to_reg;
    assign bus.ALUSrc_EX      = ex_q.alu_src;
    assign bus.RegDst_EX      = ex_q.reg_dst;
    assign bus.ALUOp_EX       = ex_q.alu_op;
    assign bus.Stall_ID       = stall;
    assign bus.Stall_Count    = stall_cnt_q;

endmodule
